// File: rtl/cpu_wait_gen.sv
// CPU wait-state generator: programmable per-cycle-type wait T-states, masked
// device wait merging, device-hold timeout watchdog and wait statistics.
module cpu_wait_gen #(
   parameter int unsigned CNT_W  = 3,
   parameter int unsigned N_DEV  = 4,
   parameter int unsigned TO_W   = 12,
   parameter int unsigned STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              m1,
   input  logic              mreq,
   input  logic              iorq,
   input  logic              rfsh,
   input  logic [CNT_W-1:0]  wait_m1,
   input  logic [CNT_W-1:0]  wait_io,
   input  logic [CNT_W-1:0]  wait_mem,
   input  logic [N_DEV-1:0]  dev_wait,
   input  logic [N_DEV-1:0]  dev_mask,
   input  logic [TO_W-1:0]   to_limit,
   input  logic              to_clr,
   input  logic              stat_clr,
   output logic              wait_n,
   output logic [1:0]        busy,
   output logic              to_flag,
   output logic [STAT_W-1:0] stat_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, load_val;
   logic [TO_W-1:0]   to_cnt, to_cnt_nxt, to_cnt_inc;
   logic              act, act_q, cyc_start, dev_act;
   logic              wait_n_nxt, timeout;

   assign act        = m1 | iorq | (mreq & ~rfsh);
   assign cyc_start  = act & ~act_q;
   assign dev_act    = |(dev_wait & dev_mask);
   assign to_cnt_inc = to_cnt + TO_W'(1);
   assign busy       = state;

   // M1 outranks IORQ so that interrupt acknowledge uses the M1 wait count
   always_comb begin
      if (m1)
         load_val = wait_m1;
      else if (iorq)
         load_val = wait_io;
      else
         load_val = wait_mem;
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      to_cnt_nxt = to_cnt;
      wait_n_nxt = wait_n;
      timeout    = 1'b0;
      if (ce) begin
         case (state)
            IDLE: begin
               if (cyc_start) begin
                  if (load_val != '0) begin
                     state_nxt  = COUNT;
                     cnt_nxt    = load_val;
                     wait_n_nxt = 1'b0;
                  end else if (dev_act) begin
                     state_nxt  = HOLD;
                     wait_n_nxt = 1'b0;
                  end else begin
                     state_nxt  = DONE;
                     wait_n_nxt = 1'b1;
                  end
               end
            end
            COUNT: begin
               if (!act) begin
                  state_nxt  = IDLE;
                  cnt_nxt    = '0;
                  wait_n_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     if (dev_act) begin
                        state_nxt = HOLD;
                     end else begin
                        state_nxt  = DONE;
                        wait_n_nxt = 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (!dev_act) begin
                  state_nxt  = DONE;
                  wait_n_nxt = 1'b1;
                  to_cnt_nxt = '0;
               end else if ((to_limit != '0) && (to_cnt_inc == to_limit)) begin
                  state_nxt  = DONE;
                  wait_n_nxt = 1'b1;
                  to_cnt_nxt = '0;
                  timeout    = 1'b1;
               end else begin
                  to_cnt_nxt = to_cnt_inc;
               end
            end
            DONE: begin
               wait_n_nxt = 1'b1;
               if (!act)
                  state_nxt = IDLE;
            end
            default: begin
               state_nxt  = IDLE;
               wait_n_nxt = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         to_cnt   <= '0;
         wait_n   <= 1'b1;
         act_q    <= 1'b0;
         to_flag  <= 1'b0;
         stat_cnt <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         to_cnt <= to_cnt_nxt;
         wait_n <= wait_n_nxt;
         if (ce) begin
            act_q <= act;
            // a timeout in the same T-state as a clear must stay visible
            if (timeout)
               to_flag <= 1'b1;
            else if (to_clr)
               to_flag <= 1'b0;
            if (stat_clr)
               stat_cnt <= '0;
            else if (!wait_n && (stat_cnt != '1))
               stat_cnt <= stat_cnt + STAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cpu_wait_gen.sv
// Self-checking bench for cpu_wait_gen: directed vector table plus hand-written
// sequences for device hold, timeout, reset abort and statistics saturation.
module tb_cpu_wait_gen;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        m1, mreq, iorq, rfsh;
   logic [2:0]  wait_m1, wait_io, wait_mem;
   logic [3:0]  dev_wait, dev_mask;
   logic [11:0] to_limit;
   logic        to_clr, stat_clr;
   logic        wait_n;
   logic [1:0]  busy;
   logic        to_flag;
   logic [15:0] stat_cnt;

   int pass_cnt  = 0;
   int check_cnt = 0;

   typedef struct {
      logic        ce, m1, mreq, iorq, rfsh, sclr;
      logic [2:0]  wm1, wio, wmem;
      logic [3:0]  dev, mask;
      logic        exp_wn;
      logic [1:0]  exp_busy;
      logic [15:0] exp_stat;
   } vec_t;

   vec_t vecs[$];

   cpu_wait_gen #(.CNT_W(3), .N_DEV(4), .TO_W(12), .STAT_W(16)) dut (
      .clk(clk), .reset(reset), .ce(ce), .m1(m1), .mreq(mreq), .iorq(iorq),
      .rfsh(rfsh), .wait_m1(wait_m1), .wait_io(wait_io), .wait_mem(wait_mem),
      .dev_wait(dev_wait), .dev_mask(dev_mask), .to_limit(to_limit),
      .to_clr(to_clr), .stat_clr(stat_clr), .wait_n(wait_n), .busy(busy),
      .to_flag(to_flag), .stat_cnt(stat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic c, input logic a_m1, input logic a_mreq,
                               input logic a_iorq, input logic a_rfsh, input logic a_sclr,
                               input logic [2:0] a_wm1, input logic [2:0] a_wio,
                               input logic [2:0] a_wmem, input logic [3:0] a_dev,
                               input logic [3:0] a_mask, input logic e_wn,
                               input logic [1:0] e_busy, input logic [15:0] e_stat);
      vec_t v;
      v.ce = c; v.m1 = a_m1; v.mreq = a_mreq; v.iorq = a_iorq; v.rfsh = a_rfsh;
      v.sclr = a_sclr; v.wm1 = a_wm1; v.wio = a_wio; v.wmem = a_wmem;
      v.dev = a_dev; v.mask = a_mask; v.exp_wn = e_wn; v.exp_busy = e_busy;
      v.exp_stat = e_stat;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act_val,
                              input logic [31:0] exp_val);
      check_cnt++;
      if (act_val !== exp_val)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act_val, exp_val);
      else
         pass_cnt++;
   endtask

   task automatic applyStimulus(input vec_t v);
      ce = v.ce; m1 = v.m1; mreq = v.mreq; iorq = v.iorq; rfsh = v.rfsh;
      stat_clr = v.sclr; wait_m1 = v.wm1; wait_io = v.wio; wait_mem = v.wmem;
      dev_wait = v.dev; dev_mask = v.mask;
      tick();
   endtask

   task automatic idleBus();
      m1 = 0; mreq = 0; iorq = 0; rfsh = 0; dev_wait = '0;
   endtask

   initial begin
      int low;

      reset = 1; ce = 1; idleBus();
      wait_m1 = 0; wait_io = 0; wait_mem = 0; dev_mask = '0;
      to_limit = '0; to_clr = 0; stat_clr = 0;
      tick(); tick();
      checkOutput("reset wait_n", 32'(wait_n), 32'd1);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset to_flag", 32'(to_flag), 32'd0);
      checkOutput("reset stat_cnt", 32'(stat_cnt), 32'd0);
      reset = 0;

      //            ce m1 mq io rf sc wm1 wio wmem dev mask wn busy stat
      vecs.push_back(mk(1,1,1,0,0,0, 1,0,0, 0,0, 1'b0,2'd1,16'd0));
      vecs.push_back(mk(1,1,1,0,0,0, 1,0,0, 0,0, 1'b1,2'd3,16'd1));
      vecs.push_back(mk(1,0,1,0,1,1, 1,0,0, 0,0, 1'b1,2'd0,16'd0));
      vecs.push_back(mk(1,1,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd0));
      vecs.push_back(mk(1,1,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd1));
      vecs.push_back(mk(1,1,0,1,0,0, 2,5,0, 0,0, 1'b1,2'd3,16'd2));
      vecs.push_back(mk(1,0,0,0,0,0, 2,5,0, 0,0, 1'b1,2'd0,16'd2));
      vecs.push_back(mk(1,0,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd2));
      vecs.push_back(mk(1,0,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd3));
      vecs.push_back(mk(1,0,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd4));
      vecs.push_back(mk(1,0,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd5));
      vecs.push_back(mk(1,0,0,1,0,0, 2,5,0, 0,0, 1'b0,2'd1,16'd6));
      vecs.push_back(mk(1,0,0,1,0,0, 2,5,0, 0,0, 1'b1,2'd3,16'd7));
      vecs.push_back(mk(1,0,0,0,0,0, 2,5,0, 0,0, 1'b1,2'd0,16'd7));
      vecs.push_back(mk(1,0,1,0,1,0, 0,0,3, 0,0, 1'b1,2'd0,16'd7));
      vecs.push_back(mk(1,0,1,0,1,0, 0,0,3, 0,0, 1'b1,2'd0,16'd7));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,3, 0,0, 1'b0,2'd1,16'd7));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,3, 0,0, 1'b0,2'd1,16'd8));
      vecs.push_back(mk(0,0,1,0,0,0, 0,0,3, 0,0, 1'b0,2'd1,16'd8));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,3, 0,0, 1'b0,2'd1,16'd9));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,3, 0,0, 1'b1,2'd3,16'd10));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,3, 0,0, 1'b1,2'd0,16'd10));
      // aborted memory cycle
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,3, 0,0, 1'b0,2'd1,16'd10));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,3, 0,0, 1'b0,2'd1,16'd11));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,3, 0,0, 1'b1,2'd0,16'd12));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,3, 0,0, 1'b1,2'd0,16'd12));
      // masked device, then device asserted only after release
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,0, 2,0, 1'b1,2'd3,16'd12));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,0, 2,0, 1'b1,2'd3,16'd12));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,0, 2,0, 1'b1,2'd0,16'd12));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 0,2, 1'b0,2'd1,16'd12));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 0,2, 1'b1,2'd3,16'd13));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 2,2, 1'b1,2'd3,16'd13));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,1, 2,2, 1'b1,2'd0,16'd13));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,1, 0,2, 1'b1,2'd0,16'd13));
      // device extends a counted cycle
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 0,2, 1'b0,2'd1,16'd13));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 2,2, 1'b0,2'd2,16'd14));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 2,2, 1'b0,2'd2,16'd15));
      vecs.push_back(mk(1,0,1,0,0,0, 0,0,1, 0,2, 1'b1,2'd3,16'd16));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,1, 0,2, 1'b1,2'd0,16'd16));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d wait_n", i), 32'(wait_n), 32'(vecs[i].exp_wn));
         checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         checkOutput($sformatf("vec%0d stat_cnt", i), 32'(stat_cnt), 32'(vecs[i].exp_stat));
      end

      ce = 1; stat_clr = 0; idleBus();
      wait_m1 = 0; wait_io = 0; wait_mem = 0; dev_mask = 4'b0010; to_limit = '0;

      // zero-wait cycle held by a device for 10 T-states
      low = 0;
      for (int i = 0; i < 10; i++) begin
         mreq = 1; dev_wait = 4'b0010; tick();
         if (!wait_n) low++;
      end
      dev_wait = '0; tick();
      checkOutput("hold low count", 32'(low), 32'd10);
      checkOutput("hold release wait_n", 32'(wait_n), 32'd1);
      checkOutput("hold release busy", 32'(busy), 32'd3);
      checkOutput("hold stat_cnt", 32'(stat_cnt), 32'd26);
      idleBus(); tick();
      checkOutput("hold idle busy", 32'(busy), 32'd0);

      // timeout after 8 T-states despite a 100 T-state hold
      to_limit = 12'd8;
      low = 0;
      for (int i = 0; i < 100; i++) begin
         mreq = 1; dev_wait = 4'b0010; tick();
         if (!wait_n) low++;
      end
      checkOutput("timeout low count", 32'(low), 32'd8);
      checkOutput("timeout to_flag", 32'(to_flag), 32'd1);
      checkOutput("timeout busy", 32'(busy), 32'd3);
      checkOutput("timeout stat_cnt", 32'(stat_cnt), 32'd34);
      idleBus(); tick();
      checkOutput("to_flag sticky", 32'(to_flag), 32'd1);
      to_clr = 1; tick(); to_clr = 0;
      checkOutput("to_flag cleared", 32'(to_flag), 32'd0);
      for (int i = 1; i <= 9; i++) begin
         mreq = 1; dev_wait = 4'b0010; to_clr = (i == 9); tick();
      end
      to_clr = 0;
      checkOutput("set beats clear to_flag", 32'(to_flag), 32'd1);
      checkOutput("set beats clear wait_n", 32'(wait_n), 32'd1);
      idleBus(); tick();
      checkOutput("second timeout stat_cnt", 32'(stat_cnt), 32'd42);

      // reset while counting with cnt=4
      to_limit = '0; wait_mem = 3'd7; mreq = 1;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("pre-reset busy", 32'(busy), 32'd1);
      checkOutput("pre-reset wait_n", 32'(wait_n), 32'd0);
      reset = 1; idleBus(); tick(); reset = 0;
      checkOutput("mid reset wait_n", 32'(wait_n), 32'd1);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset stat_cnt", 32'(stat_cnt), 32'd0);
      checkOutput("mid reset to_flag", 32'(to_flag), 32'd0);
      tick();

      // accumulate to 16'hFFFD, then three more waits must saturate
      wait_mem = 3'd0;
      for (int i = 0; i < 65533; i++) begin
         mreq = 1; dev_wait = 4'b0010; tick();
      end
      dev_wait = '0; tick();
      checkOutput("near-full stat_cnt", 32'(stat_cnt), 32'hFFFD);
      idleBus(); tick();
      wait_mem = 3'd3; mreq = 1;
      tick(); tick(); tick();
      checkOutput("stat_cnt reaches max", 32'(stat_cnt), 32'hFFFF);
      tick();
      checkOutput("stat_cnt saturated", 32'(stat_cnt), 32'hFFFF);
      idleBus(); tick();
      stat_clr = 1; tick(); stat_clr = 0;
      checkOutput("stat_clr", 32'(stat_cnt), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
